fp_writeback_arbiter: RTL and testbench
=======================================

# fp_writeback_arbiter

Write-side initiator for the floating-point register file: merges FPU results and FP load data into a single register-file write port, one write per cycle. FPU results that lose arbitration to loads are held in a small FIFO, so the FPU sees a valid/ready handshake and loads are never stalled. The block also keeps the accrued exception flags (fflags) and exports a pending-destination mask that issue logic uses for RAW hazard checks.

## Interface
- NUM_REGS, 32, number of FP registers; also the width of the pending mask
- FIFO_DEPTH, 2, FPU result buffer entries; must be 2 or more
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- fpu_valid  in  1  FPU result offered
- fpu_ready  out  1  result accepted this cycle when fpu_valid is also high
- fpu_rd  in  5  destination register
- fpu_result  in  32  result data
- fpu_flags  in  5  NV,DZ,OF,UF,NX for this result
- ld_valid  in  1  FP load data valid; always accepted, no ready
- ld_rd  in  5  load destination
- ld_data  in  32  load data
- wb_wen  out  1  register-file write enable
- wb_rd  out  5  write address
- wb_data  out  32  write data
- wb_flags  out  5  flags of the write; 0 for load writes
- fflags_wr  in  1  CSR write to fflags
- fflags_wdata  in  5  CSR write value
- fflags_acc  out  5  accrued flags
- pend_mask  out  NUM_REGS  bit i is set while a buffered FIFO entry targets register i
- busy  out  1  FIFO not empty

## Operation
- Sources are arbitrated each cycle with fixed priority:
  - ld_valid: the load goes to the wb registers. A same-cycle accepted FPU result is pushed to the FIFO, and the FIFO head is held.
  - else if the FIFO is not empty: the head is popped to the wb registers. A same-cycle accepted FPU result is pushed to the tail.
  - else if fpu_valid && fpu_ready: bypass. The result goes directly to the wb registers and is not pushed.
  - else: wb_wen <= 0. wb_rd, wb_data and wb_flags hold their previous values.
- fpu_ready = !rst && (count < FIFO_DEPTH). It is a function of the registered count only; a pop in the same cycle does not free a slot early.
- FIFO ordering is strict FIFO. FPU results are never reordered among themselves.
- Loads may overtake buffered FPU results. Issue logic must use pend_mask to avoid WAW hazards; this block does not check for them.
- Accrued flags: fflags_acc <= (fflags_wr ? fflags_wdata : fflags_acc) | flags_selected_into_wb. The CSR write and the same-cycle flags are both kept, combined by OR.
- pend_mask is combinational from the valid FIFO entries. It does not include the wb stage or the bypass path.

## Timing
- Reset, synchronous and active-high: FIFO emptied, count=0, wb_wen=0, wb_rd=0, wb_data=0, wb_flags=0, fflags_acc=0, pend_mask=0, busy=0, fpu_ready=0 while rst is high.
- Latency: a load or a bypassed FPU result presented in cycle N gives wb_wen=1 in cycle N+1.
- A buffered result is written 1 cycle after the first cycle with no ld_valid once it reaches the head.
- Full FIFO: fpu_ready=0; the FPU must hold fpu_* stable. ready rises the cycle after a pop.
- Push and pop in the same cycle: count is unchanged, and the pointers wrap modulo FIFO_DEPTH.
- Continuous ld_valid starves the FIFO. This is accepted behaviour because load bursts are bounded by the pipeline.
- Reset asserted mid-operation: buffered results are discarded and no write is issued in the reset cycle or the cycle after.

## Structure
- Package fp_wb_pkg holds:
  - typedef wb_entry_t {logic [4:0] rd; logic [31:0] data; logic [4:0] flags;}
  - constants FLAG_NV..FLAG_NX giving the bit positions
- Sub-module fp_wb_fifo: parameterized by depth, stores wb_entry_t, exposes push/pop/count/entries. The parent builds pend_mask from the exposed entries.
- The arbitration, wb register stage and fflags register live in the top level.

## Test plan
- Idle bypass: fpu_valid, rd=3, result=0x3F800000, flags=0x01, no load -> next cycle wb_wen=1, wb_rd=3, wb_data=0x3F800000, wb_flags=0x01, fflags_acc=0x01, busy stays 0.
- Collision: same cycle ld(rd=5, 0xDEADBEEF) and fpu(rd=6, 0x40000000) -> cycle+1 writes rd5 with wb_flags=0, pend_mask bit 6 set; cycle+2 writes rd6, pend_mask=0.
- Back-pressure: hold ld_valid for 4 cycles while the FPU offers 3 results -> 2 accepted, fpu_ready=0 on the third; after ld_valid drops, writes appear in order, then the third result is accepted.
- Flags: results with flags 0x10, 0x04, and a CSR write of 0x02 in the same cycle as the second result -> fflags_acc goes 0x10 then 0x06.
- Mid-operation reset: FIFO holding 2 entries, assert rst for 1 cycle -> busy=0, pend_mask=0, wb_wen=0, fflags_acc=0; no stale write after rst is released.
- Pointer wrap: 10 consecutive push/pop pairs with a load every other cycle -> write order matches FPU issue order, no loss or duplication.

Source files
------------

// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP register-file writeback arbiter.
package fp_wb_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  flags;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // Bit positions inside the 5-bit accrued exception field.
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small circular buffer for FPU results that lost arbitration; exposes every
// slot and its valid bit so the parent can derive the pending-destination mask.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       head_data,
  output logic [CNT_W-1:0]         count,
  output logic [DEPTH*ENTRY_W-1:0] entries,
  output logic [DEPTH-1:0]         entry_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W:0] offset;
    always_comb begin
      if (PTR_W'(gi) >= rd_ptr_q) begin
        offset = (PTR_W + 1)'(gi) - {1'b0, rd_ptr_q};
      end else begin
        offset = (PTR_W + 1)'(gi + DEPTH) - {1'b0, rd_ptr_q};
      end
    end
    assign entry_valid[gi] = (int'(offset) < int'(count_q));
    assign entries[gi*ENTRY_W +: ENTRY_W] = mem_q[gi];
  end

endmodule

// File: rtl/fp_writeback_arbiter.sv
// Merges FP loads and FPU results into one register-file write port, buffering
// FPU results that collide with loads, and accumulates the fflags CSR.
module fp_writeback_arbiter
  import fp_wb_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fpu_valid,
  output logic                fpu_ready,
  input  logic [4:0]          fpu_rd,
  input  logic [31:0]         fpu_result,
  input  logic [4:0]          fpu_flags,
  input  logic                ld_valid,
  input  logic [4:0]          ld_rd,
  input  logic [31:0]         ld_data,
  output logic                wb_wen,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic [4:0]          wb_flags,
  input  logic                fflags_wr,
  input  logic [4:0]          fflags_wdata,
  output logic [4:0]          fflags_acc,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic                busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                          fifo_push, fifo_pop, fpu_accept;
  logic [ENTRY_W-1:0]            fifo_head;
  logic [CNT_W-1:0]              fifo_count;
  logic [FIFO_DEPTH*ENTRY_W-1:0] fifo_entries;
  logic [FIFO_DEPTH-1:0]         fifo_valid;
  wb_entry_t                     head_entry, fpu_entry;
  wb_entry_t                     slots [FIFO_DEPTH];

  logic       wb_wen_q, wb_wen_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0] wb_flags_q, wb_flags_d;
  logic [4:0] fflags_acc_q, fflags_acc_d;

  fp_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (fpu_entry),
    .pop        (fifo_pop),
    .head_data  (fifo_head),
    .count      (fifo_count),
    .entries    (fifo_entries),
    .entry_valid(fifo_valid)
  );

  assign head_entry = wb_entry_t'(fifo_head);
  assign fpu_entry  = '{rd: fpu_rd, data: fpu_result, flags: fpu_flags};
  assign fpu_ready  = !rst && (int'(fifo_count) < FIFO_DEPTH);
  assign fpu_accept = fpu_valid && fpu_ready;

  // Loads first, then the oldest buffered result, then a direct FPU bypass.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    wb_wen_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_flags_d = wb_flags_q;
    if (ld_valid) begin
      wb_wen_d   = 1'b1;
      wb_rd_d    = ld_rd;
      wb_data_d  = ld_data;
      wb_flags_d = '0;
      fifo_push  = fpu_accept;
    end else if (fifo_count != '0) begin
      wb_wen_d   = 1'b1;
      wb_rd_d    = head_entry.rd;
      wb_data_d  = head_entry.data;
      wb_flags_d = head_entry.flags;
      fifo_pop   = 1'b1;
      fifo_push  = fpu_accept;
    end else if (fpu_accept) begin
      wb_wen_d   = 1'b1;
      wb_rd_d    = fpu_rd;
      wb_data_d  = fpu_result;
      wb_flags_d = fpu_flags;
    end
    fflags_acc_d = (fflags_wr ? fflags_wdata : fflags_acc_q)
                 | (wb_wen_d ? wb_flags_d : 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wen_q     <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_flags_q   <= '0;
      fflags_acc_q <= '0;
    end else begin
      wb_wen_q     <= wb_wen_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_flags_q   <= wb_flags_d;
      fflags_acc_q <= fflags_acc_d;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    assign slots[gi] = wb_entry_t'(fifo_entries[gi*ENTRY_W +: ENTRY_W]);
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (!rst && fifo_valid[i] && (int'(slots[i].rd) < NUM_REGS)) begin
        pend_mask[slots[i].rd] = 1'b1;
      end
    end
  end

  assign busy       = !rst && (fifo_count != '0);
  assign wb_wen     = wb_wen_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_flags   = wb_flags_q;
  assign fflags_acc = fflags_acc_q;

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed bench for fp_writeback_arbiter with hand-computed expectations.
module tb_fp_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fpu_valid, fpu_ready;
  logic [4:0]  fpu_rd, fpu_flags;
  logic [31:0] fpu_result;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wb_wen;
  logic [4:0]  wb_rd, wb_flags;
  logic [31:0] wb_data;
  logic        fflags_wr;
  logic [4:0]  fflags_wdata, fflags_acc;
  logic [31:0] pend_mask;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_writeback_arbiter #(
    .NUM_REGS  (32),
    .FIFO_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fpu_valid   (fpu_valid),
    .fpu_ready   (fpu_ready),
    .fpu_rd      (fpu_rd),
    .fpu_result  (fpu_result),
    .fpu_flags   (fpu_flags),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .wb_wen      (wb_wen),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_flags    (wb_flags),
    .fflags_wr   (fflags_wr),
    .fflags_wdata(fflags_wdata),
    .fflags_acc  (fflags_acc),
    .pend_mask   (pend_mask),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fpu_valid = 0; fpu_rd = 0; fpu_result = 0; fpu_flags = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    fflags_wr = 0; fflags_wdata = 0;
  endtask

  task automatic drive_fpu(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] f);
    fpu_valid = 1; fpu_rd = rd; fpu_result = d; fpu_flags = f;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [31:0] d);
    ld_valid = 1; ld_rd = rd; ld_data = d;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_d;
  int          sent, got;
  logic        accepted;

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    check("rst_wen", wb_wen, 0);
    check("rst_rd", wb_rd, 0);
    check("rst_data", wb_data, 0);
    check("rst_flags", wb_flags, 0);
    check("rst_fflags", fflags_acc, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", fpu_ready, 0);
    rst = 0;
    #1;
    check("ready_after_rst", fpu_ready, 1);

    // Idle bypass
    drive_fpu(5'd3, 32'h3F80_0000, 5'h01);
    tick(); idle();
    check("byp_wen", wb_wen, 1);
    check("byp_rd", wb_rd, 3);
    check("byp_data", wb_data, 32'h3F80_0000);
    check("byp_flags", wb_flags, 5'h01);
    check("byp_fflags", fflags_acc, 5'h01);
    check("byp_busy", busy, 0);
    tick();
    check("idle_wen", wb_wen, 0);
    check("idle_hold_rd", wb_rd, 3);
    check("idle_hold_data", wb_data, 32'h3F80_0000);

    // Collision
    drive_ld(5'd5, 32'hDEAD_BEEF);
    drive_fpu(5'd6, 32'h4000_0000, 5'h00);
    tick(); idle();
    check("col1_wen", wb_wen, 1);
    check("col1_rd", wb_rd, 5);
    check("col1_data", wb_data, 32'hDEAD_BEEF);
    check("col1_flags", wb_flags, 0);
    check("col1_pend", pend_mask, 32'h0000_0040);
    check("col1_busy", busy, 1);
    tick();
    check("col2_wen", wb_wen, 1);
    check("col2_rd", wb_rd, 6);
    check("col2_data", wb_data, 32'h4000_0000);
    check("col2_pend", pend_mask, 0);
    check("col2_busy", busy, 0);

    // Back-pressure: 4 load cycles, 3 FPU offers
    drive_ld(5'd10, 32'hA000_000A); drive_fpu(5'd20, 32'h2000_0014, 0);
    check("bp0_ready", fpu_ready, 1);
    tick();
    check("bp0_rd", wb_rd, 10);
    drive_ld(5'd11, 32'hA000_000B); drive_fpu(5'd21, 32'h2000_0015, 0);
    check("bp1_ready", fpu_ready, 1);
    tick();
    check("bp1_rd", wb_rd, 11);
    check("bp1_pend", pend_mask, 32'h0030_0000);
    drive_ld(5'd12, 32'hA000_000C); drive_fpu(5'd22, 32'h2000_0016, 0);
    check("bp2_ready", fpu_ready, 0);
    tick();
    check("bp2_rd", wb_rd, 12);
    drive_ld(5'd13, 32'hA000_000D);
    check("bp3_ready", fpu_ready, 0);
    tick();
    check("bp3_rd", wb_rd, 13);
    ld_valid = 0;
    check("bp4_ready", fpu_ready, 0);
    tick();
    check("bp4_wen", wb_wen, 1);
    check("bp4_rd", wb_rd, 20);
    check("bp4_data", wb_data, 32'h2000_0014);
    check("bp5_ready", fpu_ready, 1);
    tick(); idle();
    check("bp5_rd", wb_rd, 21);
    check("bp5_pend", pend_mask, 32'h0040_0000);
    tick();
    check("bp6_rd", wb_rd, 22);
    check("bp6_data", wb_data, 32'h2000_0016);
    check("bp6_busy", busy, 0);
    check("bp_fflags", fflags_acc, 5'h01);

    // Flags accrual with a concurrent CSR write
    fflags_wr = 1; fflags_wdata = 0;
    tick(); idle();
    check("fl_clear", fflags_acc, 0);
    drive_fpu(5'd1, 32'h1, 5'h10);
    tick(); idle();
    check("fl_first", fflags_acc, 5'h10);
    drive_fpu(5'd2, 32'h2, 5'h04);
    fflags_wr = 1; fflags_wdata = 5'h02;
    tick(); idle();
    check("fl_second", fflags_acc, 5'h06);

    // Mid-operation reset with two buffered results
    drive_ld(5'd0, 32'hA0); drive_fpu(5'd7, 32'h7, 5'h01);
    tick();
    drive_ld(5'd0, 32'hA1); drive_fpu(5'd8, 32'h8, 5'h01);
    tick(); idle();
    check("mr_busy_pre", busy, 1);
    check("mr_pend_pre", pend_mask, 32'h0000_0180);
    rst = 1;
    #1;
    check("mr_ready_inrst", fpu_ready, 0);
    check("mr_pend_inrst", pend_mask, 0);
    tick();
    check("mr_wen", wb_wen, 0);
    check("mr_fflags", fflags_acc, 0);
    check("mr_busy", busy, 0);
    check("mr_pend", pend_mask, 0);
    rst = 0;
    tick();
    check("mr_nostale1", wb_wen, 0);
    check("mr_busy_post", busy, 0);
    tick();
    check("mr_nostale2", wb_wen, 0);

    // Pointer wrap: 10 results, loads every other cycle
    sent = 0; got = 0;
    for (int k = 0; k < 80 && got < 10; k++) begin
      ld_valid = (k % 2 == 0);
      ld_rd = 0;
      ld_data = 32'hA000_0000 + k;
      fpu_valid = (sent < 10);
      fpu_rd = 5'(sent + 1);
      fpu_result = 32'h1000 + sent;
      fpu_flags = 0;
      accepted = fpu_valid && fpu_ready;
      tick();
      if (accepted) begin
        exp_q.push_back(32'h1000 + sent);
        sent++;
      end
      if (wb_wen && wb_data[31:12] == 20'h00001) begin
        if (exp_q.size() == 0) begin
          check("wrap_unexpected", wb_data, 32'hFFFF_FFFF);
        end else begin
          exp_d = exp_q.pop_front();
          check("wrap_data", wb_data, exp_d);
          check("wrap_rd", wb_rd, exp_d[4:0] + 1);
        end
        got++;
      end
    end
    idle();
    check("wrap_sent", sent, 10);
    check("wrap_got", got, 10);
    tick(); tick();
    check("wrap_busy", busy, 0);
    check("wrap_leftover", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
